// File: rtl/generic_1bit_mux_if.sv
// Bit-select bus for generic_1bit_mux: data vector and index in, selected bit and range flag out.
// The master drives x/s and observes z/sel_err; the mux itself sits on the slave side.
interface generic_1bit_mux_if #(
    parameter int INs = 5
) ();
    localparam int SW = (INs > 1) ? $clog2(INs) : 1;

    logic [INs-1:0] x;
    logic [SW-1:0]  s;
    logic           z;
    logic           sel_err;

    modport master (
        output x,
        output s,
        input  z,
        input  sel_err
    );

    modport slave (
        input  x,
        input  s,
        output z,
        output sel_err
    );
endinterface

// File: rtl/generic_1bit_mux.sv
// N-input, 1-bit multiplexer with registered output and an out-of-range select flag.
// Synchronous active-low reset clears both outputs and takes priority over data.
module generic_1bit_mux #(
    parameter int INs = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    generic_1bit_mux_if.slave   bus
);
    localparam int SW = (INs > 1) ? $clog2(INs) : 1;

    logic [INs-1:0] w_dec;
    logic           w_sel_bit;
    logic           w_in_range;
    logic           r_z;
    logic           r_sel_err;

    // One-hot decode of the select; masking with the decode keeps X on unselected bits out of z.
    always_comb begin
        w_dec = {INs{1'b0}};
        for (int i = 0; i < INs; i++) begin
            w_dec[i] = (32'(bus.s) == 32'(i));
        end
        w_sel_bit  = |(bus.x & w_dec);
        w_in_range = |w_dec;
    end

    // Output register: reset first, otherwise load the selected bit and range flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_z       <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_z       <= w_sel_bit;
            r_sel_err <= ~w_in_range;
        end
    end

    assign bus.z       = r_z;
    assign bus.sel_err = r_sel_err;
endmodule

// File: tb/tb_generic_1bit_mux.sv
// Self-checking bench for generic_1bit_mux at INs = 5, 8 and 1, driven in lockstep.
// Expected outputs come from an arithmetic model of the selection rule.
module tb_generic_1bit_mux;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    generic_1bit_mux_if #(.INs(5)) bus5 ();
    generic_1bit_mux_if #(.INs(8)) bus8 ();
    generic_1bit_mux_if #(.INs(1)) bus1 ();

    generic_1bit_mux #(.INs(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
    generic_1bit_mux #(.INs(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    generic_1bit_mux #(.INs(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_z(input int n, input int xv, input int sv, input bit run);
        if (!run)   return 1'b0;
        if (sv < n) return ((xv >> sv) & 1) != 0;
        return 1'b0;
    endfunction

    function automatic logic ref_err(input int n, input int sv, input bit run);
        return run && (sv >= n);
    endfunction

    // Apply one set of inputs, clock once, then compare all outputs against the model.
    task automatic step(input bit run, input logic [7:0] xv, input logic [2:0] sv, input logic s1v);
        rst_n  = run;
        bus5.x = xv[4:0];
        bus5.s = sv;
        bus8.x = xv;
        bus8.s = sv;
        bus1.x = xv[0];
        bus1.s = s1v;
        @(posedge clk);
        #1;
        check_bit("z5",   bus5.z,       ref_z(5, int'(xv[4:0]), int'(sv), run));
        check_bit("err5", bus5.sel_err, ref_err(5, int'(sv), run));
        check_bit("z8",   bus8.z,       ref_z(8, int'(xv), int'(sv), run));
        check_bit("err8", bus8.sel_err, ref_err(8, int'(sv), run));
        check_bit("z1",   bus1.z,       ref_z(1, int'(xv[0]), int'(s1v), run));
        check_bit("err1", bus1.sel_err, ref_err(1, int'(s1v), run));
    endtask

    initial begin
        rst_n  = 1'b0;
        bus5.x = 5'd0; bus5.s = 3'd0;
        bus8.x = 8'd0; bus8.s = 3'd0;
        bus1.x = 1'b0; bus1.s = 1'b0;

        // Reset held two edges with all-ones data.
        step(1'b0, 8'h1F, 3'd0, 1'b0);
        step(1'b0, 8'h1F, 3'd0, 1'b0);

        // Sweep every legal select.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h15, 3'(i), 1'b0);

        // Out-of-range selects, then recovery.
        step(1'b1, 8'h15, 3'd5, 1'b1);
        step(1'b1, 8'h15, 3'd7, 1'b1);
        step(1'b1, 8'h15, 3'd0, 1'b0);

        // Hold s=2, toggle x[2], then change only unselected bits.
        step(1'b1, 8'h04, 3'd2, 1'b0);
        step(1'b1, 8'h1B, 3'd2, 1'b0);
        step(1'b1, 8'h00, 3'd2, 1'b0);
        step(1'b1, 8'h1B, 3'd2, 1'b0);

        // Mid-stream reset pulse.
        step(1'b1, 8'h01, 3'd0, 1'b0);
        step(1'b0, 8'h01, 3'd0, 1'b0);
        step(1'b1, 8'h01, 3'd0, 1'b0);

        // Top select at INs=8 and the single-input corner.
        step(1'b1, 8'h80, 3'd7, 1'b0);
        step(1'b1, 8'h01, 3'd0, 1'b0);
        step(1'b1, 8'h01, 3'd0, 1'b1);

        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 19) != 0), 8'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
